// File: rtl/dispatch_ctrl.sv
// Dispatch stage: structural/WAW hazard checks against a register status table,
// registered FUST-row output, branch freeze and halt drain.
module dispatch_ctrl #(
    parameter int NUM_FU   = 5,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 3,
    parameter int REG_W    = 5
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TAG_W-1:0]   in_fu,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rs1,
    input  logic [REG_W-1:0]   in_rs2,
    input  logic               in_wr_en,
    input  logic               in_is_branch,
    input  logic               in_is_halt,
    input  logic [NUM_FU-1:0]  fu_busy,
    input  logic               wb_valid,
    input  logic [TAG_W-1:0]   wb_tag,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic               branch_resolved,
    input  logic               branch_miss,
    output logic               disp_valid,
    output logic [TAG_W-1:0]   disp_fu,
    output logic [REG_W-1:0]   disp_rd,
    output logic               disp_wr_en,
    output logic [TAG_W-1:0]   disp_t1,
    output logic [TAG_W-1:0]   disp_t2,
    output logic               freeze,
    output logic               halt
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_BR_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    localparam logic [TAG_W-1:0] FU_LIM = TAG_W'(NUM_FU);

    logic [1:0]       state, state_nx;
    logic [TAG_W-1:0] rst_tab [NUM_REGS];

    logic             fu_hit, struct_haz, waw_haz, miss_now;
    logic             accept, disp_en, set_en, all_clear;
    logic [TAG_W-1:0] set_tag, eff_rd, eff_rs1, eff_rs2;

    // Tag as seen this cycle, with a matching writeback bypassed to "ready".
    function automatic logic [TAG_W-1:0] eff(input logic [REG_W-1:0] r);
        if (r == '0 || (wb_valid && wb_rd == r && wb_tag == rst_tab[r]))
            return '0;
        return rst_tab[r];
    endfunction

    always_comb begin
        eff_rd  = eff(in_rd);
        eff_rs1 = eff(in_rs1);
        eff_rs2 = eff(in_rs2);
    end

    always_comb begin
        fu_hit = 1'b0;
        for (int unsigned k = 0; k < NUM_FU; k++)
            if (in_fu == TAG_W'(k)) fu_hit = fu_busy[k];
    end

    always_comb begin
        all_clear = 1'b1;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            if (rst_tab[r] != '0) all_clear = 1'b0;
    end

    always_comb begin
        struct_haz = fu_hit | (disp_valid & (disp_fu == in_fu)) | (in_fu >= FU_LIM);
        waw_haz    = in_wr_en & (in_rd != '0) & (eff_rd != '0);
        miss_now   = branch_resolved & branch_miss;
        in_ready   = nRST & (state == S_RUN) & ~miss_now &
                     (in_is_halt | (~struct_haz & ~waw_haz));
        accept     = in_valid & in_ready;
        disp_en    = accept & ~in_is_halt;
        set_en     = disp_en & in_wr_en & (in_rd != '0);
        set_tag    = in_fu + 1'b1;
        freeze     = (state == S_BR_WAIT) | (state == S_HALTED);
        halt       = (state == S_HALTED);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN: begin
                if (accept && in_is_halt)        state_nx = S_DRAIN;
                else if (accept && in_is_branch) state_nx = S_BR_WAIT;
            end
            S_BR_WAIT: if (branch_resolved) state_nx = S_RUN;
            S_DRAIN:   if (all_clear && fu_busy == '0) state_nx = S_HALTED;
            default:   state_nx = S_HALTED;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= S_RUN;
        else       state <= state_nx;
    end

    // Dispatch write takes priority over a same-cycle writeback clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) rst_tab[r] <= '0;
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (set_en && in_rd == REG_W'(r))
                    rst_tab[r] <= set_tag;
                else if (wb_valid && wb_rd == REG_W'(r) && wb_tag == rst_tab[r])
                    rst_tab[r] <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            disp_valid <= 1'b0;
            disp_fu    <= '0;
            disp_rd    <= '0;
            disp_wr_en <= 1'b0;
            disp_t1    <= '0;
            disp_t2    <= '0;
        end else begin
            disp_valid <= disp_en;
            if (disp_en) begin
                disp_fu    <= in_fu;
                disp_rd    <= in_rd;
                disp_wr_en <= in_wr_en;
                disp_t1    <= eff_rs1;
                disp_t2    <= eff_rs2;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Randomized bench for dispatch_ctrl against a behavioural scoreboard model.
module tb_dispatch_ctrl;
    localparam int NUM_FU   = 5;
    localparam int NUM_REGS = 32;
    localparam int TAG_W    = 3;
    localparam int REG_W    = 5;

    logic              CLK = 1'b0;
    logic              nRST = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [TAG_W-1:0]  in_fu = '0;
    logic [REG_W-1:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic              in_wr_en = 1'b0, in_is_branch = 1'b0, in_is_halt = 1'b0;
    logic [NUM_FU-1:0] fu_busy = '0;
    logic              wb_valid = 1'b0;
    logic [TAG_W-1:0]  wb_tag = '0;
    logic [REG_W-1:0]  wb_rd = '0;
    logic              branch_resolved = 1'b0, branch_miss = 1'b0;
    logic              disp_valid, disp_wr_en, freeze, halt;
    logic [TAG_W-1:0]  disp_fu, disp_t1, disp_t2;
    logic [REG_W-1:0]  disp_rd;

    always #5 CLK = ~CLK;

    dispatch_ctrl #(.NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .in_fu(in_fu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_wr_en(in_wr_en), .in_is_branch(in_is_branch), .in_is_halt(in_is_halt),
        .fu_busy(fu_busy), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_rd(wb_rd),
        .branch_resolved(branch_resolved), .branch_miss(branch_miss),
        .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_rd(disp_rd),
        .disp_wr_en(disp_wr_en), .disp_t1(disp_t1), .disp_t2(disp_t2),
        .freeze(freeze), .halt(halt)
    );

    typedef enum int {M_RUN, M_BR, M_DRAIN, M_HALT} mstate_t;
    mstate_t m_state;
    int      m_rst [NUM_REGS];
    int      m_dv, m_dfu, m_drd, m_dwr, m_t1, m_t2;
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int r);
        if (r == 0) return 0;
        if (wb_valid && int'(wb_rd) == r && int'(wb_tag) == m_rst[r]) return 0;
        return m_rst[r];
    endfunction

    function automatic bit exp_ready();
        int fu = int'(in_fu);
        if (!nRST || m_state != M_RUN) return 0;
        if (branch_resolved && branch_miss) return 0;
        if (in_is_halt) return 1;
        if (fu >= NUM_FU) return 0;
        if (fu_busy[fu] || (m_dv != 0 && m_dfu == fu)) return 0;
        if (in_wr_en && in_rd != 0 && eff(int'(in_rd)) != 0) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        m_state = M_RUN;
        foreach (m_rst[r]) m_rst[r] = 0;
        m_dv = 0; m_dfu = 0; m_drd = 0; m_dwr = 0; m_t1 = 0; m_t2 = 0;
    endtask

    // Called at a falling edge after inputs are driven; returns just after the rising edge.
    task automatic cycle_step();
        bit rdy, acc, clear;
        int t1, t2, wr;
        #1;
        rdy = exp_ready();
        chk("in_ready", in_ready, rdy);
        chk("freeze", freeze, (m_state == M_BR || m_state == M_HALT));
        chk("halt", halt, m_state == M_HALT);
        chk("disp_valid", disp_valid, m_dv);
        if (m_dv != 0) begin
            chk("disp_fu", disp_fu, m_dfu);
            chk("disp_rd", disp_rd, m_drd);
            chk("disp_wr_en", disp_wr_en, m_dwr);
            chk("disp_t1", disp_t1, m_t1);
            chk("disp_t2", disp_t2, m_t2);
        end
        acc   = in_valid && rdy;
        clear = 1;
        foreach (m_rst[r]) if (m_rst[r] != 0) clear = 0;
        t1 = eff(int'(in_rs1));
        t2 = eff(int'(in_rs2));
        wr = int'(wb_rd);
        if (wb_valid && wr != 0 && int'(wb_tag) == m_rst[wr]) m_rst[wr] = 0;
        if (acc && !in_is_halt) begin
            m_dv = 1; m_dfu = int'(in_fu); m_drd = int'(in_rd); m_dwr = int'(in_wr_en);
            m_t1 = t1; m_t2 = t2;
            if (in_wr_en && in_rd != 0) m_rst[int'(in_rd)] = int'(in_fu) + 1;
        end else begin
            m_dv = 0;
        end
        case (m_state)
            M_RUN: begin
                if (acc && in_is_halt)        m_state = M_DRAIN;
                else if (acc && in_is_branch) m_state = M_BR;
            end
            M_BR:    if (branch_resolved) m_state = M_RUN;
            M_DRAIN: if (clear && fu_busy == 0) m_state = M_HALT;
            default: ;
        endcase
        @(posedge CLK);
    endtask

    task automatic rand_inputs(input int c);
        int k, r;
        in_valid = ($urandom % 4) != 0;
        in_fu    = ($urandom % 16 == 0) ? TAG_W'(5 + $urandom % 3) : TAG_W'($urandom % 5);
        in_rd    = REG_W'($urandom % 12);
        in_rs1   = REG_W'($urandom % 12);
        in_rs2   = REG_W'($urandom % 12);
        in_wr_en = ($urandom % 4) != 0;
        k = int'($urandom % 48);
        in_is_branch = (k < 3);
        in_is_halt   = (c > 80 && k == 3);
        fu_busy  = NUM_FU'($urandom & $urandom & $urandom);
        wb_valid = $urandom % 2;
        if ($urandom % 3 == 0 && in_wr_en) r = int'(in_rd);
        else r = int'($urandom % 12);
        wb_rd  = REG_W'(r);
        wb_tag = ($urandom % 5 == 0) ? TAG_W'($urandom % 8) : TAG_W'(m_rst[r]);
        branch_resolved = ($urandom % 4) == 0;
        branch_miss     = $urandom % 2;
    endtask

    // Entered at a falling edge; leaves at a falling edge with reset released.
    task automatic do_reset(input int c);
        rand_inputs(c);
        in_valid = 1'b1;
        nRST = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_halt", halt, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_fu", disp_fu, 0);
        chk("rst_disp_rd", disp_rd, 0);
        chk("rst_disp_wr_en", disp_wr_en, 0);
        chk("rst_disp_t1", disp_t1, 0);
        chk("rst_disp_t2", disp_t2, 0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        int len;
        model_reset();
        @(negedge CLK);
        do_reset(0);
        for (int ep = 0; ep < 10; ep++) begin
            len = 120 + int'($urandom % 150);
            for (int c = 0; c < len; c++) begin
                rand_inputs(c);
                cycle_step();
                @(negedge CLK);
            end
            do_reset(len);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
